// File: rtl/merge_pass_scheduler_if.sv
// Merge descriptor handshake between merge_pass_scheduler (master) and merge_phase (slave).
`ifndef BANK_ADDR_WIDTH
`define BANK_ADDR_WIDTH 7
`endif

interface merge_pass_scheduler_if #(
  parameter int ADDR_W = `BANK_ADDR_WIDTH + 1
);
  logic              merge_start_out;
  logic [ADDR_W-1:0] merge_a_base_out;
  logic [ADDR_W:0]   merge_a_len_out;
  logic [ADDR_W-1:0] merge_b_base_out;
  logic [ADDR_W:0]   merge_b_len_out;
  logic [ADDR_W-1:0] merge_dst_base_out;
  logic              merge_src_sel_out;
  logic              merge_done_in;

  modport master (
    output merge_start_out, merge_a_base_out, merge_a_len_out, merge_b_base_out,
           merge_b_len_out, merge_dst_base_out, merge_src_sel_out,
    input  merge_done_in
  );

  modport slave (
    input  merge_start_out, merge_a_base_out, merge_a_len_out, merge_b_base_out,
           merge_b_len_out, merge_dst_base_out, merge_src_sel_out,
    output merge_done_in
  );
endinterface

// File: rtl/merge_pass_scheduler.sv
// Bottom-up merge pass sequencer: walks run pairs of length L between ping and pong,
// issuing one descriptor at a time to merge_phase and doubling L after each pass.
`ifndef BANK_ADDR_WIDTH
`define BANK_ADDR_WIDTH 7
`endif

module merge_pass_scheduler #(
  parameter int ADDR_W   = `BANK_ADDR_WIDTH + 1,
  parameter int BASE_RUN = 16
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   stream_done_in,
  input  logic [ADDR_W:0]        count_in,
  input  logic                   sort_phase_done_in,
  merge_pass_scheduler_if.master merge_bus,
  output logic                   sort_done,
  output logic                   result_sel_out,
  output logic [4:0]             pass_count_out,
  output logic                   busy_out
);
  // Two spare bits keep base + 2L from wrapping.
  localparam int CW = ADDR_W + 2;

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    WAIT_SORT  = 3'd1,
    SETUP      = 3'd2,
    ISSUE      = 3'd3,
    WAIT_MERGE = 3'd4,
    NEXT       = 3'd5,
    DONE       = 3'd6
  } state_t;

  state_t            state_r, state_s;
  logic [ADDR_W:0]   n_r, n_s;
  logic [CW-1:0]     len_r, len_s, base_r, base_s;
  logic              sel_r, sel_s;
  logic [4:0]        pass_r, pass_s;
  logic              start_r, start_s;
  logic [ADDR_W-1:0] a_base_r, a_base_s, b_base_r, b_base_s;
  logic [ADDR_W:0]   a_len_r, a_len_s, b_len_r, b_len_s;
  logic              done_r, done_s;
  logic              busy_r, busy_s;

  logic [CW-1:0] n_ext_s, remain_s, b_end_s, b_remain_s;
  logic [CW-1:0] a_len_calc_s, b_len_calc_s, base_step_s, len_dbl_s;

  // Descriptor and pass-advance arithmetic for the current (base, L) pair.
  always_comb begin
    n_ext_s      = CW'(n_r);
    remain_s     = n_ext_s - base_r;
    b_end_s      = base_r + len_r;
    b_remain_s   = n_ext_s - b_end_s;
    len_dbl_s    = {len_r[CW-2:0], 1'b0};
    base_step_s  = base_r + len_dbl_s;
    a_len_calc_s = (len_r < remain_s) ? len_r : remain_s;
    b_len_calc_s = {CW{1'b0}};
    if (b_end_s >= n_ext_s) begin
      b_len_calc_s = {CW{1'b0}};
    end else if (len_r < b_remain_s) begin
      b_len_calc_s = len_r;
    end else begin
      b_len_calc_s = b_remain_s;
    end
  end

  // Next-state and next-output logic; every register holds unless a state updates it.
  always_comb begin
    state_s  = state_r;
    n_s      = n_r;
    len_s    = len_r;
    base_s   = base_r;
    sel_s    = sel_r;
    pass_s   = pass_r;
    start_s  = 1'b0;
    a_base_s = a_base_r;
    a_len_s  = a_len_r;
    b_base_s = b_base_r;
    b_len_s  = b_len_r;
    done_s   = done_r;
    case (state_r)
      IDLE: begin
        if (stream_done_in) begin
          n_s     = count_in;
          state_s = WAIT_SORT;
        end else begin
          state_s = IDLE;
        end
      end
      WAIT_SORT: begin
        if (sort_phase_done_in) begin
          len_s  = CW'(BASE_RUN);
          base_s = {CW{1'b0}};
          sel_s  = 1'b0;
          pass_s = 5'd0;
          if (n_ext_s <= CW'(BASE_RUN)) begin
            state_s = DONE;
            done_s  = 1'b1;
          end else begin
            state_s = SETUP;
          end
        end else begin
          state_s = WAIT_SORT;
        end
      end
      SETUP: begin
        a_base_s = ADDR_W'(base_r);
        a_len_s  = (ADDR_W+1)'(a_len_calc_s);
        b_base_s = ADDR_W'(b_end_s);
        b_len_s  = (ADDR_W+1)'(b_len_calc_s);
        start_s  = 1'b1;
        state_s  = ISSUE;
      end
      ISSUE: begin
        state_s = WAIT_MERGE;
      end
      WAIT_MERGE: begin
        if (merge_bus.merge_done_in) begin
          state_s = NEXT;
        end else begin
          state_s = WAIT_MERGE;
        end
      end
      NEXT: begin
        if (base_step_s < n_ext_s) begin
          base_s  = base_step_s;
          state_s = SETUP;
        end else begin
          pass_s = pass_r + 5'd1;
          sel_s  = ~sel_r;
          len_s  = len_dbl_s;
          base_s = {CW{1'b0}};
          if (len_dbl_s >= n_ext_s) begin
            state_s = DONE;
            done_s  = 1'b1;
          end else begin
            state_s = SETUP;
          end
        end
      end
      DONE: begin
        if (stream_done_in) begin
          done_s  = 1'b0;
          n_s     = count_in;
          state_s = WAIT_SORT;
        end else begin
          state_s = DONE;
        end
      end
      default: begin
        state_s = IDLE;
      end
    endcase
    busy_s = (state_s != IDLE) && (state_s != DONE);
  end

  // State and output registers; reset clears everything at once, even mid-pass.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_r  <= IDLE;
      n_r      <= {(ADDR_W+1){1'b0}};
      len_r    <= {CW{1'b0}};
      base_r   <= {CW{1'b0}};
      sel_r    <= 1'b0;
      pass_r   <= 5'd0;
      start_r  <= 1'b0;
      a_base_r <= {ADDR_W{1'b0}};
      a_len_r  <= {(ADDR_W+1){1'b0}};
      b_base_r <= {ADDR_W{1'b0}};
      b_len_r  <= {(ADDR_W+1){1'b0}};
      done_r   <= 1'b0;
      busy_r   <= 1'b0;
    end else begin
      state_r  <= state_s;
      n_r      <= n_s;
      len_r    <= len_s;
      base_r   <= base_s;
      sel_r    <= sel_s;
      pass_r   <= pass_s;
      start_r  <= start_s;
      a_base_r <= a_base_s;
      a_len_r  <= a_len_s;
      b_base_r <= b_base_s;
      b_len_r  <= b_len_s;
      done_r   <= done_s;
      busy_r   <= busy_s;
    end
  end

  assign merge_bus.merge_start_out    = start_r;
  assign merge_bus.merge_a_base_out   = a_base_r;
  assign merge_bus.merge_a_len_out    = a_len_r;
  assign merge_bus.merge_b_base_out   = b_base_r;
  assign merge_bus.merge_b_len_out    = b_len_r;
  assign merge_bus.merge_dst_base_out = a_base_r;
  assign merge_bus.merge_src_sel_out  = sel_r;
  assign sort_done                    = done_r;
  assign result_sel_out               = sel_r;
  assign pass_count_out               = pass_r;
  assign busy_out                     = busy_r;

endmodule

// File: tb/tb_merge_pass_scheduler.sv
// Directed + randomized bench for merge_pass_scheduler against a run-list reference model.
module tb_merge_pass_scheduler;
  localparam int ADDR_W   = 8;
  localparam int BASE_RUN = 16;

  logic            clock = 1'b0;
  logic            reset = 1'b0;
  logic            stream_done_in = 1'b0;
  logic [ADDR_W:0] count_in = '0;
  logic            sort_phase_done_in = 1'b0;
  logic            sort_done;
  logic            result_sel_out;
  logic [4:0]      pass_count_out;
  logic            busy_out;

  int n_vec = 0;
  int n_err = 0;

  typedef struct {
    int a_base;
    int a_len;
    int b_base;
    int b_len;
    bit sel;
    int pass;
  } desc_t;

  desc_t exp_q[$];

  merge_pass_scheduler_if #(.ADDR_W(ADDR_W)) mbus();

  merge_pass_scheduler #(.ADDR_W(ADDR_W), .BASE_RUN(BASE_RUN)) dut (
    .clock              (clock),
    .reset              (reset),
    .stream_done_in     (stream_done_in),
    .count_in           (count_in),
    .sort_phase_done_in (sort_phase_done_in),
    .merge_bus          (mbus),
    .sort_done          (sort_done),
    .result_sel_out     (result_sel_out),
    .pass_count_out     (pass_count_out),
    .busy_out           (busy_out)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] obs_desc();
    return 64'({mbus.merge_a_base_out, mbus.merge_a_len_out, mbus.merge_b_base_out,
                mbus.merge_b_len_out, mbus.merge_dst_base_out, mbus.merge_src_sel_out});
  endfunction

  function automatic logic [63:0] exp_desc(input desc_t d);
    return 64'({ADDR_W'(d.a_base), (ADDR_W+1)'(d.a_len), ADDR_W'(d.b_base),
                (ADDR_W+1)'(d.b_len), ADDR_W'(d.a_base), d.sel});
  endfunction

  function automatic logic [63:0] all_outputs();
    return 64'({obs_desc(), mbus.merge_start_out, sort_done, result_sel_out,
                pass_count_out, busy_out});
  endfunction

  // Reference: the list of merges of a bottom-up merge sort over n entries.
  task automatic build_model(input int n, output int passes);
    desc_t d;
    exp_q.delete();
    passes = 0;
    for (int len = BASE_RUN; len < n; len = len * 2) begin
      for (int base = 0; base < n; base = base + 2 * len) begin
        d.a_base = base;
        d.a_len  = (n - base < len) ? n - base : len;
        d.b_base = base + len;
        d.b_len  = (base + len >= n) ? 0 : ((n - base - len < len) ? n - base - len : len);
        d.sel    = passes[0];
        d.pass   = passes;
        exp_q.push_back(d);
      end
      passes++;
    end
  endtask

  task automatic do_reset();
    #2 reset = 1'b0;
    #1 check("reset_async_outputs", all_outputs(), 64'd0);
    repeat (3) @(negedge clock);
    check("reset_held_outputs", all_outputs(), 64'd0);
    reset = 1'b1;
    @(negedge clock);
    check("post_reset_outputs", all_outputs(), 64'd0);
  endtask

  task automatic run_sort(input int n, input int abort_idx);
    int  passes;
    int  d;
    int  hold;
    bit  start_seen;
    build_model(n, passes);
    stream_done_in = 1'b1;
    count_in       = (ADDR_W+1)'(n);
    @(negedge clock);
    stream_done_in = 1'b0;
    count_in       = (ADDR_W+1)'($urandom);
    check("sort_done_cleared", sort_done, 64'd0);
    check("busy_wait_sort", busy_out, 64'd1);
    repeat ($urandom_range(0, 3)) @(negedge clock);
    sort_phase_done_in = 1'b1;
    @(negedge clock);
    sort_phase_done_in = 1'b0;
    d = 1;
    for (int i = 0; i < exp_q.size(); i++) begin
      while (!mbus.merge_start_out && d < 40) begin
        @(negedge clock);
        d++;
      end
      check(i == 0 ? "first_start_latency" : "next_start_latency", d, (i == 0) ? 2 : 3);
      check("descriptor", obs_desc(), exp_desc(exp_q[i]));
      check("pass_count_mid", pass_count_out, exp_q[i].pass);
      check("busy_mid", busy_out, 64'd1);
      // merge_done coincident with merge_start must be ignored
      mbus.merge_done_in = 1'b1;
      @(negedge clock);
      mbus.merge_done_in = 1'b0;
      check("start_one_cycle", mbus.merge_start_out, 64'd0);
      hold = $urandom_range(5, 20);
      for (int c = 0; c < hold; c++) begin
        stream_done_in = (c == 1);
        count_in       = (ADDR_W+1)'($urandom);
        @(negedge clock);
        check("hold_descriptor", obs_desc(), exp_desc(exp_q[i]));
        check("hold_no_start", mbus.merge_start_out, 64'd0);
        if (i == abort_idx && c == 2) begin
          stream_done_in = 1'b0;
          do_reset();
          return;
        end
      end
      stream_done_in     = 1'b0;
      mbus.merge_done_in = 1'b1;
      @(negedge clock);
      mbus.merge_done_in = 1'b0;
      d = 1;
    end
    start_seen = 1'b0;
    while (!sort_done && d < 40) begin
      if (mbus.merge_start_out) start_seen = 1'b1;
      @(negedge clock);
      d++;
    end
    check("no_extra_start", start_seen, 64'd0);
    check("done_latency", d, (exp_q.size() == 0) ? 1 : 2);
    check("sort_done", sort_done, 64'd1);
    check("result_sel", result_sel_out, passes % 2);
    check("pass_count", pass_count_out, passes);
    check("busy_done", busy_out, 64'd0);
    repeat ($urandom_range(1, 4)) @(negedge clock);
    check("done_holds", sort_done, 64'd1);
  endtask

  initial begin
    mbus.merge_done_in = 1'b0;
    #1 check("reset_state", all_outputs(), 64'd0);
    repeat (2) @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    check("idle_after_reset", all_outputs(), 64'd0);

    run_sort(64, -1);
    run_sort(40, -1);
    run_sort(16, -1);
    run_sort(0, -1);
    repeat (4) run_sort($urandom_range(17, 200), -1);
    run_sort(128, 4);
    run_sort(128, -1);
    run_sort(32, -1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
